dmem_mmio_responder: RTL and testbench



---
 rtl/mmio_pkg.sv | 27 ++
 rtl/dmem_mmio_responder_if.sv | 11 +
 rtl/mmio_button_sync.sv | 41 ++++
 rtl/dmem_mmio_responder.sv | 150 +++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared constants, register offsets and helpers for the data-memory / MMIO responder.
package mmio_pkg;

  localparam logic [31:0] MMIO_BASE = 32'hFFFF_FF00;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam logic [2:0] OFF_BTN_LIVE    = 3'd0;
  localparam logic [2:0] OFF_BTN_EVENT   = 3'd1;
  localparam logic [2:0] OFF_TIMER       = 3'd2;
  localparam logic [2:0] OFF_TICK_PERIOD = 3'd3;
  localparam logic [2:0] OFF_RANDOM      = 3'd4;
  localparam logic [2:0] OFF_SCORE       = 3'd5;
  localparam logic [2:0] OFF_LED         = 3'd6;
  localparam logic [2:0] OFF_STATUS      = 3'd7;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_NONE
  } region_e;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// Processor data-memory bus: XM-stage request and half-cycle read data.
interface dmem_mmio_responder_if;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic        rden;
  logic [31:0] q_dmem;

  modport master (output address_dmem, output data, output wren, output rden, input q_dmem);
  modport slave  (input address_dmem, input data, input wren, input rden, output q_dmem);
endinterface

// File: rtl/mmio_button_sync.sv
// Button synchronizer, rising-edge detector and sticky event flags.
module mmio_button_sync #(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] btn_i,
  input  logic         clr_i,
  output logic [W-1:0] live_o,
  output logic [W-1:0] event_o
);

  logic [W-1:0] s1_q, s2_q, prev_q, flag_q;
  logic [W-1:0] flag_d;
  logic [W-1:0] edge_c;

  // A new edge wins over a coincident clear so no press is lost.
  always_comb begin
    edge_c = s2_q & ~prev_q;
    flag_d = (flag_q & ~{W{clr_i}}) | edge_c;
  end

  // Synchronizer, previous-value and flag registers on the falling edge.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      flag_q <= '0;
    end else begin
      s1_q   <= btn_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      flag_q <= flag_d;
    end
  end

  assign live_o  = s2_q;
  assign event_o = flag_q;

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data RAM plus game MMIO page, answering the XM-stage load/store bus on the falling edge.
module dmem_mmio_responder
  import mmio_pkg::*;
#(
  parameter int unsigned RAM_AW    = 12,
  parameter int unsigned BTN_W     = 4,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic                 clock,
  input  logic                 reset,
  dmem_mmio_responder_if.slave dmem,
  input  logic [BTN_W-1:0]     buttons,
  output logic [31:0]          score,
  output logic [15:0]          leds,
  output logic                 tick_pending
);

  localparam int unsigned RAM_WORDS = 1 << RAM_AW;

  logic [31:0] mem_q [RAM_WORDS];

  logic [31:0] q_dmem_q, q_dmem_d;
  logic [31:0] period_q, period_d;
  logic [31:0] presc_q, presc_d;
  logic [31:0] timer_q, timer_d;
  logic        tick_q, tick_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] score_q, score_d;
  logic [15:0] led_q, led_d;

  region_e     region;
  logic [2:0]  offset;
  logic        rd_fx, mmio_wr, mmio_rd, ram_we;
  logic        btn_clr, status_clr;
  logic [BTN_W-1:0] btn_live, btn_event;

  // Address decode and strobe qualification; a store with rden set is a store only.
  always_comb begin
    region = REGION_NONE;
    if (dmem.address_dmem[31:RAM_AW] == '0) begin
      region = REGION_RAM;
    end else if (dmem.address_dmem[31:3] == MMIO_BASE[31:3]) begin
      region = REGION_MMIO;
    end
    offset     = dmem.address_dmem[2:0];
    rd_fx      = dmem.rden & ~dmem.wren;
    mmio_wr    = dmem.wren & (region == REGION_MMIO);
    mmio_rd    = rd_fx & (region == REGION_MMIO);
    ram_we     = dmem.wren & (region == REGION_RAM);
    btn_clr    = mmio_rd & (offset == OFF_BTN_EVENT);
    status_clr = mmio_rd & (offset == OFF_STATUS);
  end

  mmio_button_sync #(.W(BTN_W)) u_btn (
    .clock   (clock),
    .reset   (reset),
    .btn_i   (buttons),
    .clr_i   (btn_clr),
    .live_o  (btn_live),
    .event_o (btn_event)
  );

  // Register next-state: prescaler/timer, LFSR, writable registers and read mux.
  always_comb begin
    period_d = period_q;
    presc_d  = presc_q;
    timer_d  = timer_q;
    tick_d   = tick_q & ~status_clr;
    lfsr_d   = lfsr_step(lfsr_q);
    score_d  = score_q;
    led_d    = led_q;
    q_dmem_d = 32'h0000_0000;

    if (period_q == 32'd0) begin
      presc_d = 32'd0;
    end else if (presc_q == period_q - 32'd1) begin
      presc_d = 32'd0;
      timer_d = timer_q + 32'd1;
      tick_d  = 1'b1;
    end else begin
      presc_d = presc_q + 32'd1;
    end

    if (mmio_wr) begin
      case (offset)
        OFF_TICK_PERIOD: begin
          period_d = dmem.data;
          presc_d  = 32'd0;
        end
        OFF_SCORE: score_d = dmem.data;
        OFF_LED:   led_d   = dmem.data[15:0];
        default:   ;
      endcase
    end

    case (region)
      REGION_RAM: q_dmem_d = mem_q[dmem.address_dmem[RAM_AW-1:0]];
      REGION_MMIO: begin
        case (offset)
          OFF_BTN_LIVE:    q_dmem_d = 32'(btn_live);
          OFF_BTN_EVENT:   q_dmem_d = 32'(btn_event);
          OFF_TIMER:       q_dmem_d = timer_q;
          OFF_TICK_PERIOD: q_dmem_d = period_q;
          OFF_RANDOM:      q_dmem_d = lfsr_q;
          OFF_SCORE:       q_dmem_d = score_q;
          OFF_LED:         q_dmem_d = {16'h0000, led_q};
          OFF_STATUS:      q_dmem_d = {31'h0000_0000, tick_q};
          default:         q_dmem_d = 32'h0000_0000;
        endcase
      end
      default: q_dmem_d = 32'h0000_0000;
    endcase
  end

  // All architectural state and read data update on the falling edge.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      q_dmem_q <= 32'h0000_0000;
      period_q <= 32'h0000_0000;
      presc_q  <= 32'h0000_0000;
      timer_q  <= 32'h0000_0000;
      tick_q   <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      score_q  <= 32'h0000_0000;
      led_q    <= 16'h0000;
    end else begin
      q_dmem_q <= q_dmem_d;
      period_q <= period_d;
      presc_q  <= presc_d;
      timer_q  <= timer_d;
      tick_q   <= tick_d;
      lfsr_q   <= lfsr_d;
      score_q  <= score_d;
      led_q    <= led_d;
    end
  end

  // RAM array is not reset; a store arriving while reset is held is dropped.
  always_ff @(negedge clock) begin
    if (!reset && ram_we) begin
      mem_q[dmem.address_dmem[RAM_AW-1:0]] <= dmem.data;
    end
  end

  assign dmem.q_dmem  = q_dmem_q;
  assign score        = score_q;
  assign leds         = led_q;
  assign tick_pending = tick_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench for dmem_mmio_responder: stimulus pushes expectations, a monitor checks them.
module tb_dmem_mmio_responder;

  localparam logic [31:0] MB   = 32'hFFFF_FF00;
  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam int K_Q     = 0;
  localparam int K_SCORE = 1;
  localparam int K_LEDS  = 2;
  localparam int K_TICK  = 3;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  buttons = 4'h0;
  logic [31:0] score;
  logic [15:0] leds;
  logic        tick_pending;
  bit          chk_tgl = 1'b0;

  int total = 0;
  int bad   = 0;
  chk_t sb[$];

  dmem_mmio_responder_if bus();

  dmem_mmio_responder #(
    .RAM_AW    (12),
    .BTN_W     (4),
    .LFSR_SEED (SEED)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .dmem         (bus),
    .buttons      (buttons),
    .score        (score),
    .leds         (leds),
    .tick_pending (tick_pending)
  );

  always #5 clock = ~clock;

  // Reference LFSR: shift right, fold taps in when the bit shifted out was 1.
  function automatic logic [31:0] ref_step(input logic [31:0] r);
    logic lsb;
    lsb = r[0];
    r = r >> 1;
    if (lsb) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  logic [31:0] m_lfsr;
  always @(negedge clock or posedge reset) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= ref_step(m_lfsr);
  end

  task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    @(posedge clock);
    #1;
    bus.address_dmem = a;
    bus.data         = d;
    bus.wren         = w;
    bus.rden         = r;
  endtask

  task automatic idle();
    drive(32'h0001_0000, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(a, d, 1'b1, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    drive(a, 32'h0, 1'b0, 1'b1);
    expect_val(K_Q, exp, name);
  endtask

  // Monitor: after each falling edge (or an explicit async check) compare all pending entries.
  initial begin
    chk_t c;
    logic [31:0] act;
    forever begin
      @(negedge clock or chk_tgl);
      #1;
      while (sb.size() > 0) begin
        c = sb.pop_front();
        case (c.kind)
          K_SCORE: act = score;
          K_LEDS:  act = {16'h0000, leds};
          K_TICK:  act = {31'h0, tick_pending};
          default: act = bus.q_dmem;
        endcase
        total++;
        if (act !== c.exp) begin
          bad++;
          $display("FAIL %s: got %08h expected %08h", c.name, act, c.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.address_dmem = 32'h0001_0000;
    bus.data = 32'h0;
    bus.wren = 1'b0;
    bus.rden = 1'b0;
    repeat (3) @(posedge clock);

    // Release reset and read RANDOM on the very first falling edge.
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.address_dmem = MB + 32'd4;
    bus.rden = 1'b1;
    expect_val(K_Q, SEED, "rand_seed");
    rd(MB + 32'd4, 32'h5670_9234, "rand_step1");
    rd(MB + 32'd0, 32'h0, "btn_live_rst");
    rd(MB + 32'd1, 32'h0, "btn_event_rst");
    rd(MB + 32'd2, 32'h0, "timer_rst");
    rd(MB + 32'd3, 32'h0, "period_rst");
    rd(MB + 32'd5, 32'h0, "score_rst");
    rd(MB + 32'd6, 32'h0, "led_rst");
    rd(MB + 32'd7, 32'h0, "status_rst");
    rd(32'h0001_0000, 32'h0, "unmapped_rd");
    expect_val(K_SCORE, 32'h0, "score_out_rst");
    expect_val(K_LEDS, 32'h0, "leds_out_rst");
    expect_val(K_TICK, 32'h0, "tick_out_rst");

    // RAM: half-cycle read, top word, out-of-range alias must not write.
    wr(32'h0, 32'h1111_1111);
    wr(32'h5, 32'h1234_5678);
    rd(32'h5, 32'h1234_5678, "ram_5");
    wr(32'hFFF, 32'hA5A5_5A5A);
    rd(32'hFFF, 32'hA5A5_5A5A, "ram_fff");
    rd(32'h0, 32'h1111_1111, "ram_0");
    wr(32'h1000, 32'hDEAD_DEAD);
    rd(32'h1000, 32'h0, "above_ram_rd");
    rd(32'h0, 32'h1111_1111, "ram_0_no_alias");

    // Button press held for three clocks.
    idle(); buttons = 4'h4;
    idle();
    rd(MB + 32'd0, 32'h4, "btn_live");
    rd(MB + 32'd1, 32'h4, "btn_event");
    buttons = 4'h0;
    rd(MB + 32'd1, 32'h0, "btn_event_cleared");
    idle(); idle(); idle();

    // Edge arriving on the same edge as the clearing read.
    idle(); buttons = 4'h4;
    idle();
    rd(MB + 32'd1, 32'h0, "btn_event_coincident");
    rd(MB + 32'd1, 32'h4, "btn_event_after");
    buttons = 4'h0;
    idle(); idle(); idle();

    // Prescaler with period 5.
    wr(MB + 32'd3, 32'd5);
    idle(); idle(); idle();
    idle(); expect_val(K_TICK, 32'h0, "tick_before");
    idle(); expect_val(K_TICK, 32'h1, "tick_rise");
    rd(MB + 32'd7, 32'h1, "status_set");
    rd(MB + 32'd2, 32'h1, "timer_1");
    expect_val(K_TICK, 32'h0, "tick_cleared");
    rd(MB + 32'd3, 32'd5, "period_rb");
    idle();
    rd(MB + 32'd7, 32'h0, "status_coincident");
    expect_val(K_TICK, 32'h1, "tick_kept");
    rd(MB + 32'd2, 32'h2, "timer_2");
    wr(MB + 32'd3, 32'd0);
    repeat (7) idle();
    rd(MB + 32'd2, 32'h2, "timer_frozen");
    wr(MB + 32'd2, 32'd99);
    rd(MB + 32'd2, 32'h2, "timer_ro");
    rd(MB + 32'd7, 32'h1, "status_again");
    rd(MB + 32'd7, 32'h0, "status_clear2");

    // LED, RANDOM (read-only) and SCORE.
    wr(MB + 32'd6, 32'hDEAD_BEEF);
    rd(MB + 32'd6, 32'h0000_BEEF, "led_rd");
    expect_val(K_LEDS, 32'h0000_BEEF, "leds_out");
    wr(MB + 32'd4, 32'h0);
    drive(MB + 32'd4, 32'h0, 1'b0, 1'b1);
    expect_val(K_Q, m_lfsr, "rand_after_wr");
    wr(MB + 32'd5, 32'd7);
    rd(MB + 32'd5, 32'd7, "score_rd");
    expect_val(K_SCORE, 32'd7, "score_out");

    // Reset in the middle of prescaling, with a store pending.
    wr(32'h10, 32'hCAFE_F00D);
    wr(MB + 32'd3, 32'd3);
    idle(); idle();
    rd(MB + 32'd5, 32'd7, "score_pre_rst");
    expect_val(K_TICK, 32'h1, "tick_pre_rst");
    drive(32'h10, 32'h0BAD_0BAD, 1'b1, 1'b0);
    #1;
    reset = 1'b1;
    expect_val(K_Q, 32'h0, "q_async_rst");
    expect_val(K_SCORE, 32'h0, "score_async_rst");
    expect_val(K_TICK, 32'h0, "tick_async_rst");
    expect_val(K_LEDS, 32'h0, "leds_async_rst");
    chk_tgl = ~chk_tgl;
    @(negedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.address_dmem = 32'h10;
    bus.wren = 1'b0;
    bus.rden = 1'b1;
    expect_val(K_Q, 32'hCAFE_F00D, "ram_survives_rst");
    rd(MB + 32'd5, 32'h0, "score_after_rst");
    idle(); idle();

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
